// File: rtl/video_spi_loader_if.sv
// Write port from the SPI loader into the video frame bank.
`timescale 1ns/1ps
interface video_spi_loader_if #(
   parameter int ADDR_W = 12
);
   logic              bank_full;
   logic              bank_wr_en;
   logic [ADDR_W-1:0] bank_wr_addr;
   logic [7:0]        bank_wr_data;
   logic              frame_done;

   modport master (
      input  bank_full,
      output bank_wr_en, bank_wr_addr, bank_wr_data, frame_done
   );

   modport slave (
      output bank_full,
      input  bank_wr_en, bank_wr_addr, bank_wr_data, frame_done
   );
endinterface

// File: rtl/video_spi_loader.sv
// Deserialises 1-bpp pixel bytes from MISO (paced by SPI_clk_en) and writes
// them sequentially into the frame bank, honouring bank_full backpressure.
`timescale 1ns/1ps
module video_spi_loader #(
   parameter int FRAME_BYTES = 2400,
   parameter int ADDR_W      = 12
) (
   input  logic                CLK_40,
   input  logic                reset_n,
   input  logic                video_bank_we,
   input  logic                SPI_clk_en,
   input  logic                MISO,
   output logic                SPI_CS_N,
   output logic                spi_active,
   video_spi_loader_if.master  bank
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WRITE,
      HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        shift_q;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              last_bit;

   assign last_bit = (state_q == SHIFT) && SPI_clk_en && (bit_cnt_q == 3'd7);

   always_comb begin
      state_d    = state_q;
      SPI_CS_N   = 1'b0;
      spi_active = 1'b0;
      case (state_q)
         IDLE: begin
            SPI_CS_N = 1'b1;
            if (video_bank_we && !bank.bank_full) state_d = SHIFT;
         end
         SHIFT: begin
            spi_active = 1'b1;
            // An in-flight byte always completes, even if enable drops or the bank fills.
            if (last_bit) state_d = WRITE;
         end
         WRITE: begin
            if (!video_bank_we)      state_d = IDLE;
            else if (bank.bank_full) state_d = HOLD;
            else                     state_d = SHIFT;
         end
         HOLD: begin
            if (!video_bank_we)       state_d = IDLE;
            else if (!bank.bank_full) state_d = SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         addr_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == SHIFT && SPI_clk_en) begin
            shift_q   <= {shift_q[5:0], MISO};
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end
         if (last_bit) data_q <= {shift_q, MISO};
         if (state_q == WRITE) begin
            if (addr_q == LAST_ADDR) addr_q <= '0;
            else                     addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   assign bank.bank_wr_en   = (state_q == WRITE);
   assign bank.bank_wr_addr = addr_q;
   assign bank.bank_wr_data = data_q;
   assign bank.frame_done   = (state_q == WRITE) && (addr_q == LAST_ADDR);

endmodule

// File: doc/video_spi_loader.md
Name: video_spi_loader

Overview:
- Upstream feeder for the video frame bank: deserialises 1-bpp Bad Apple pixel data arriving on MISO into bytes and writes them sequentially into the bank.
- Bit sampling is paced by the shared SPI_clk_en strobe from clk_en_gen.
- Owns SPI chip-select and a request line that gates SCK generation.
- Honours bank_full backpressure and flags each completed frame.

Parameters:
- FRAME_BYTES, 2400, bytes per frame (160x120 pixels at 1 bpp); address wraps after FRAME_BYTES-1.
- ADDR_W, 12, width of bank_wr_addr; must satisfy 2^ADDR_W >= FRAME_BYTES.

Ports:
- CLK_40  input  1  system clock, 40 MHz, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- video_bank_we  input  1  level enable; loading runs while high.
- SPI_clk_en  input  1  one-cycle strobe marking the MISO sample point; spacing guaranteed >= 4 CLK_40 cycles.
- MISO  input  1  serial pixel data, MSB first.
- bank_full  input  1  almost-full from the bank; while high, at most one more byte is accepted.
- SPI_CS_N  output  1  SPI chip select, active-low.
- spi_active  output  1  high when the loader wants SCK toggling and strobes delivered.
- bank_wr_en  output  1  one-cycle write strobe to the bank.
- bank_wr_addr  output  ADDR_W  byte address for the current write.
- bank_wr_data  output  8  assembled byte; first-received bit lands in bit 7.
- frame_done  output  1  one-cycle pulse coincident with the write of byte FRAME_BYTES-1.

Behaviour:
- Reset (async assert, sync release): state IDLE; SPI_CS_N=1; spi_active=0; bank_wr_en=0; bank_wr_addr=0; bank_wr_data=0; frame_done=0; bit counter=0; shift register=0.
- States:
  - IDLE: SPI_CS_N=1, spi_active=0. Moves to SHIFT when video_bank_we=1 and bank_full=0. SPI_CS_N=0 and spi_active=1 from the next cycle.
  - SHIFT: SPI_CS_N=0, spi_active=1. On each SPI_clk_en, shift <= {shift[6:0], MISO} and bit_cnt++ (3-bit). On the 8th strobe (bit_cnt==7), the full byte is registered into bank_wr_data, bit_cnt wraps to 0, and the FSM goes to WRITE.
  - WRITE (exactly 1 cycle): bank_wr_en=1 with the current bank_wr_addr. Next cycle: addr increments, or wraps to 0 if it was FRAME_BYTES-1. frame_done=1 in this same cycle when addr==FRAME_BYTES-1. Next state, by priority:
    - video_bank_we=0 -> IDLE.
    - bank_full=1 -> HOLD.
    - otherwise -> SHIFT.
  - HOLD: SPI_CS_N stays 0 (transaction kept open), spi_active=0. Goes to SHIFT when bank_full=0, or to IDLE if video_bank_we=0 first (video_bank_we=0 takes priority).
- Latency: bank_wr_en is asserted in the cycle after the 8th SPI_clk_en cycle, so one byte is written per 8 strobes plus 1 cycle.
- SPI_clk_en outside SHIFT (IDLE, WRITE, HOLD) is ignored and never shifted in.
- bank_full rising during SHIFT: the in-flight byte completes and is written (the one-byte slack), then the FSM enters HOLD.
- video_bank_we falling mid-byte: the current byte completes and is written, then IDLE. bank_wr_addr is retained, so the next enable resumes at the same address.
- bank_wr_addr resets only on reset_n or frame wrap; it is never cleared by IDLE.
- bank_wr_data holds its last value between writes.
- reset_n asserted mid-byte: partial bits are discarded and all outputs return to reset values immediately.

Test Plan:
- Reset then video_bank_we=1, bank_full=0, drive MISO bits 1,0,1,0,0,1,0,1 on 8 strobes -> one bank_wr_en pulse with addr 0, data 0xA5, the cycle after the 8th strobe; SPI_CS_N=0 throughout.
- Stream 3 bytes 0x00, 0xFF, 0x3C -> writes at addr 0, 1, 2 with matching data; exactly 3 bank_wr_en pulses.
- Raise bank_full after 4 bits of byte 1 -> byte 1 still written at addr 1; spi_active=0 and strobes ignored while full. Drop bank_full -> byte 2 written at addr 2 and equals the next 8 post-resume bits.
- FRAME_BYTES=4 override, stream 5 bytes -> frame_done pulses only with the addr-3 write; 5th byte written at addr 0.
- Drop video_bank_we after bit 3 -> byte completes and is written, then SPI_CS_N=1, spi_active=0. Re-enable -> next write at the following address.
- Assert reset_n low after bit 5 -> all outputs return to reset values asynchronously. After release and enable, the next 8 bits form a byte written at addr 0.
